xbus_slave_responder: RTL and testbench



---
 rtl/xbus_slave_responder.sv | 157 +++++++++++++++
 tb/tb_xbus_slave_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/xbus_slave_responder.sv
// XBUS slave responder: decodes address phases inside [MIN_ADDR, MAX_ADDR] and
// serves byte-per-beat data phases from an internal byte memory, with wait states and overrun errors.
module xbus_slave_responder #(
  parameter int          NUM_MASTERS = 2,
  parameter logic [15:0] MIN_ADDR    = 16'h0000,
  parameter logic [15:0] MAX_ADDR    = 16'h00FF,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                   sig_clock,
  input  logic                   sig_reset_n,
  input  logic [NUM_MASTERS-1:0] sig_grant,
  input  logic [15:0]            sig_addr,
  input  logic [1:0]             sig_size,
  input  logic                   sig_read,
  input  logic                   sig_write,
  input  logic [7:0]             sig_data_in,
  output logic [7:0]             sig_data_out,
  output logic                   sig_data_oe,
  output logic                   sig_wait,
  output logic                   sig_error
);

  localparam int          DEPTH     = int'(MAX_ADDR) - int'(MIN_ADDR) + 1;
  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] SPAN      = MAX_ADDR - MIN_ADDR;
  localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  state_t      state;
  logic [15:0] cur_addr;
  logic [3:0]  beats_left;
  logic [3:0]  wait_cnt;
  logic        dir_read;
  logic        err;

  logic [7:0]  mem [DEPTH];

  // address-phase decode
  logic [3:0]  req_beats;
  logic [16:0] req_end;
  logic [15:0] req_off;
  logic        req_hit;
  logic        req_err;

  always_comb begin
    req_beats = 4'd1 << sig_size;
    req_end   = {1'b0, sig_addr} + {13'd0, req_beats} - 17'd1;
    req_err   = req_end > {1'b0, MAX_ADDR};
    req_off   = sig_addr - MIN_ADDR;
    req_hit   = (|sig_grant) && (req_off <= SPAN) && (sig_read ^ sig_write);
  end

  // Outputs are registered, so the read port looks up the byte of the *next* beat.
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;

  always_comb begin
    case (state)
      S_IDLE:  rd_addr = sig_addr;
      S_WAIT:  rd_addr = cur_addr;
      default: rd_addr = cur_addr + 16'd1;
    endcase
    rd_data = mem[AW'(rd_addr - MIN_ADDR)];
  end

  always_ff @(posedge sig_clock) begin
    if (state == S_BEAT && !dir_read && !err)
      mem[AW'(cur_addr - MIN_ADDR)] <= sig_data_in;
  end

  always_ff @(posedge sig_clock or negedge sig_reset_n) begin
    if (!sig_reset_n) begin
      state        <= S_IDLE;
      cur_addr     <= '0;
      beats_left   <= '0;
      wait_cnt     <= '0;
      dir_read     <= 1'b0;
      err          <= 1'b0;
      sig_data_out <= '0;
      sig_data_oe  <= 1'b0;
      sig_wait     <= 1'b0;
      sig_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sig_data_out <= '0;
          sig_data_oe  <= 1'b0;
          sig_wait     <= 1'b0;
          sig_error    <= 1'b0;
          if (req_hit) begin
            cur_addr    <= sig_addr;
            beats_left  <= req_beats;
            dir_read    <= sig_read;
            err         <= req_err;
            wait_cnt    <= WAIT_LOAD;
            sig_data_oe <= sig_read;
            if (HAS_WAIT && !req_err) begin
              state    <= S_WAIT;
              sig_wait <= 1'b1;
            end else begin
              state        <= S_BEAT;
              sig_error    <= req_err;
              sig_data_out <= (sig_read && !req_err) ? rd_data : 8'h00;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state        <= S_BEAT;
            sig_wait     <= 1'b0;
            sig_error    <= err;
            sig_data_oe  <= dir_read;
            sig_data_out <= (dir_read && !err) ? rd_data : 8'h00;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_BEAT: begin
          cur_addr   <= cur_addr + 16'd1;
          beats_left <= beats_left - 4'd1;
          if (beats_left == 4'd1) begin
            state        <= S_IDLE;
            sig_data_out <= '0;
            sig_data_oe  <= 1'b0;
            sig_wait     <= 1'b0;
            sig_error    <= 1'b0;
          end else if (HAS_WAIT && !err) begin
            state        <= S_WAIT;
            wait_cnt     <= WAIT_LOAD;
            sig_wait     <= 1'b1;
            sig_error    <= 1'b0;
            sig_data_oe  <= dir_read;
            sig_data_out <= '0;
          end else begin
            sig_wait     <= 1'b0;
            sig_error    <= err;
            sig_data_oe  <= dir_read;
            sig_data_out <= (dir_read && !err) ? rd_data : 8'h00;
          end
        end

        default: begin
          state        <= S_IDLE;
          sig_data_out <= '0;
          sig_data_oe  <= 1'b0;
          sig_wait     <= 1'b0;
          sig_error    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_slave_responder.sv
// Bench for xbus_slave_responder: one instance with no wait states, one with two,
// each checked cycle by cycle against a transfer-level model of the window memory.
module tb_xbus_slave_responder;

  localparam int MIN = 16'h0000;
  localparam int MAX = 16'h00FF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [1:0]  grant [2];
  logic [15:0] addr  [2];
  logic [1:0]  size  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [7:0]  din   [2];
  logic [7:0]  dout  [2];
  logic        oe    [2];
  logic        wt    [2];
  logic        er    [2];

  logic [7:0]  mem_m [2][256];

  int total = 0;
  int bad   = 0;

  xbus_slave_responder #(.NUM_MASTERS(2), .MIN_ADDR(16'h0000), .MAX_ADDR(16'h00FF), .WAIT_CYCLES(0)) dut0 (
    .sig_clock(clk), .sig_reset_n(rst_n[0]), .sig_grant(grant[0]), .sig_addr(addr[0]),
    .sig_size(size[0]), .sig_read(rd[0]), .sig_write(wr[0]), .sig_data_in(din[0]),
    .sig_data_out(dout[0]), .sig_data_oe(oe[0]), .sig_wait(wt[0]), .sig_error(er[0]));

  xbus_slave_responder #(.NUM_MASTERS(2), .MIN_ADDR(16'h0000), .MAX_ADDR(16'h00FF), .WAIT_CYCLES(2)) dut2 (
    .sig_clock(clk), .sig_reset_n(rst_n[1]), .sig_grant(grant[1]), .sig_addr(addr[1]),
    .sig_size(size[1]), .sig_read(rd[1]), .sig_write(wr[1]), .sig_data_in(din[1]),
    .sig_data_out(dout[1]), .sig_data_oe(oe[1]), .sig_wait(wt[1]), .sig_error(er[1]));

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in(input int d);
    grant[d] = '0; addr[d] = '0; size[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; din[d] = '0;
  endtask

  task automatic check_quiet(input int d, input string tag);
    chk({tag, "_oe"},   16'(oe[d]), 16'h0);
    chk({tag, "_wait"}, 16'(wt[d]), 16'h0);
    chk({tag, "_err"},  16'(er[d]), 16'h0);
    chk({tag, "_dout"}, 16'(dout[d]), 16'h0);
  endtask

  // One complete transfer on instance d; rst_at >= 0 pulls reset during that beat.
  task automatic xfer(input int d, input logic [15:0] a, input logic [1:0] sz, input logic r,
                      input logic w, input logic [63:0] wdat, input int rst_at);
    int beats, last, wn;
    bit acc, e;
    logic [7:0] b8;
    beats = 1 << sz;
    last  = int'(a) + beats - 1;
    acc   = (int'(a) >= MIN) && (int'(a) <= MAX) && (r ^ w);
    e     = last > MAX;
    wn    = wc(d);

    @(posedge clk); #1;
    grant[d] = 2'b01 << $urandom_range(0, 1);
    addr[d] = a; size[d] = sz; rd[d] = r; wr[d] = w; din[d] = 8'($urandom);
    @(negedge clk);
    check_quiet(d, "aphase");

    if (!acc) begin
      repeat (3) begin
        @(posedge clk); #1; idle_in(d);
        @(negedge clk); check_quiet(d, "noresp");
      end
      return;
    end

    for (int b = 0; b < beats; b++) begin
      if (!e) begin
        for (int k = 0; k < wn; k++) begin
          @(posedge clk); #1; idle_in(d);
          @(negedge clk);
          chk("ws_wait", 16'(wt[d]), 16'h1);
          chk("ws_err",  16'(er[d]), 16'h0);
          chk("ws_oe",   16'(oe[d]), 16'(r));
          if (r) chk("ws_dout", 16'(dout[d]), 16'h0);
        end
      end
      @(posedge clk); #1; idle_in(d);
      b8 = wdat[8*b +: 8];
      din[d] = b8;
      if (b == rst_at) begin
        rst_n[d] = 1'b0;
        #1;
        check_quiet(d, "midrst");
        @(posedge clk); #1;
        rst_n[d] = 1'b1;
        return;
      end
      @(negedge clk);
      chk("beat_wait", 16'(wt[d]), 16'h0);
      chk("beat_err",  16'(er[d]), 16'(e));
      chk("beat_oe",   16'(oe[d]), 16'(r));
      if (r) chk("beat_dout", 16'(dout[d]), e ? 16'h0 : 16'(mem_m[d][int'(a) + b]));
      if (w && !e) mem_m[d][int'(a) + b] = b8;
    end
  endtask

  initial begin
    int d, op;
    logic [15:0] a;
    logic r, w;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      idle_in(i);
    end

    // reset held: requests are ignored and outputs stay low
    repeat (4) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        grant[i] = 2'b10; addr[i] = 16'($urandom_range(0, 255)); size[i] = 2'($urandom);
        rd[i] = 1'b1; wr[i] = 1'b0; din[i] = 8'($urandom);
      end
      @(negedge clk);
      check_quiet(0, "rst0");
      check_quiet(1, "rst2");
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin rst_n[i] = 1'b1; idle_in(i); end
    @(negedge clk);
    check_quiet(0, "post_rst0");
    check_quiet(1, "post_rst2");

    // fill both memories with known random contents
    for (int i = 0; i < 2; i++)
      for (int blk = 0; blk < 32; blk++)
        xfer(i, 16'(blk * 8), 2'b11, 1'b0, 1'b1, {$urandom, $urandom}, -1);

    // single write then read, no wait states
    xfer(0, 16'h0010, 2'b00, 1'b0, 1'b1, 64'hA5, -1);
    xfer(0, 16'h0010, 2'b00, 1'b1, 1'b0, 64'h0, -1);
    chk("a5_model", 16'(mem_m[0][16]), 16'h00A5);

    // 8-byte burst with two wait states per beat
    xfer(1, 16'h0020, 2'b11, 1'b0, 1'b1, 64'h0807060504030201, -1);
    xfer(1, 16'h0020, 2'b11, 1'b1, 1'b0, 64'h0, -1);

    // overrun at the top of the window, both instances
    for (int i = 0; i < 2; i++) begin
      xfer(i, 16'h00FE, 2'b10, 1'b1, 1'b0, 64'h0, -1);
      xfer(i, 16'h00FE, 2'b10, 1'b0, 1'b1, 64'hFFEEDDCC, -1);
      xfer(i, 16'h00FE, 2'b01, 1'b1, 1'b0, 64'h0, -1);
    end

    // no response: out of window, and read+write together
    xfer(0, 16'h0100, 2'b00, 1'b1, 1'b0, 64'h0, -1);
    xfer(0, 16'h0010, 2'b00, 1'b1, 1'b1, 64'h0, -1);
    xfer(1, 16'h0100, 2'b01, 1'b1, 1'b0, 64'h0, -1);

    // reset in the second beat of a write, then read back
    xfer(0, 16'h0040, 2'b10, 1'b0, 1'b1, 64'h44332211, 1);
    xfer(0, 16'h0040, 2'b10, 1'b1, 1'b0, 64'h0, -1);
    xfer(0, 16'h0040, 2'b10, 1'b1, 1'b0, 64'h0, 2);
    xfer(1, 16'h0048, 2'b10, 1'b0, 1'b1, 64'h99887766, 2);
    xfer(1, 16'h0048, 2'b10, 1'b1, 1'b0, 64'h0, -1);

    // random traffic, back to back
    repeat (120) begin
      d = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(256, 65535));
        1:       a = 16'($urandom_range(248, 255));
        default: a = 16'($urandom_range(0, 255));
      endcase
      op = $urandom_range(0, 9);
      r  = (op < 4) || (op == 8);
      w  = (op >= 4 && op < 8) || (op == 8);
      xfer(d, a, 2'($urandom), r, w, {$urandom, $urandom}, -1);
    end

    @(posedge clk); #1;
    @(negedge clk);
    check_quiet(0, "end0");
    check_quiet(1, "end2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
